// File: rtl/cic3_decim_ctrl.sv
// cic3_decim_ctrl: sequencing controller for the 3rd-order CIC decimator.
// Generates the decimated filter clock, holds the filter in reset while idle
// or flushing, discards the settling outputs and captures each later filter
// output into a holding register with a valid/ready handshake.
//
// state  | meaning
// IDLE   | stopped; filter held in reset, decimation exponent latched on enable
// FLUSH  | two cycles with the filter still in reset
// SETTLE | divided clock running; first SETTLE_SAMPLES outputs discarded
// RUN    | divided clock running; every output captured for readout
module cic3_decim_ctrl #(
  parameter int MAX_DEC_LOG2   = 8,
  parameter int NUMBITS        = 25,
  parameter int SETTLE_SAMPLES = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [3:0]         dec_log2,
  input  logic [NUMBITS-1:0] cic_out,
  output logic               divided_clk,
  output logic               filter_reset_n,
  output logic [NUMBITS-1:0] sample_data,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               overrun,
  input  logic               overrun_clr,
  output logic               busy
);

  // One extra bit so D itself (e.g. 256) is representable for the wrap compare.
  localparam int CW = MAX_DEC_LOG2 + 1;
  localparam int DW = (SETTLE_SAMPLES < 2) ? 1 : $clog2(SETTLE_SAMPLES + 1);

  typedef enum logic [1:0] {IDLE, FLUSH, SETTLE, RUN} state_t;

  state_t                  state;
  logic [3:0]              eff_q;
  logic [3:0]              eff_in;
  logic [MAX_DEC_LOG2-1:0] counter;
  logic                    flush_cnt;
  logic [DW-1:0]           discard_cnt;

  logic [CW-1:0]           cnt_ext;
  logic [CW-1:0]           d_last;
  logic [CW-1:0]           half;
  logic [CW-1:0]           cap_pt;
  logic                    at_cap;

  // Clamp the requested exponent to the supported range [3, MAX_DEC_LOG2].
  always_comb begin
    eff_in = dec_log2;
    if (dec_log2 < 4'd3)
      eff_in = 4'd3;
    else if (dec_log2 > 4'(MAX_DEC_LOG2))
      eff_in = 4'(MAX_DEC_LOG2);
  end

  // Period decode for the latched ratio: wrap value, half period, capture point.
  always_comb begin
    cnt_ext = {1'b0, counter};
    d_last  = (CW'(1) << eff_q) - CW'(1);
    half    = CW'(1) << (eff_q - 4'd1);
    cap_pt  = half + CW'(2);
    at_cap  = (cnt_ext == cap_pt);
  end

  // Sequencer, divided clock generation and sample capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      eff_q          <= 4'd3;
      counter        <= '0;
      flush_cnt      <= 1'b0;
      discard_cnt    <= '0;
      divided_clk    <= 1'b0;
      filter_reset_n <= 1'b0;
      sample_data    <= '0;
      sample_valid   <= 1'b0;
      overrun        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      // A set later in this block overrides the clear.
      if (overrun_clr)
        overrun <= 1'b0;

      if (state == IDLE) begin
        counter        <= '0;
        divided_clk    <= 1'b0;
        filter_reset_n <= 1'b0;
        sample_valid   <= 1'b0;
        if (enable) begin
          eff_q     <= eff_in;
          flush_cnt <= 1'b0;
          state     <= FLUSH;
          busy      <= 1'b1;
        end
      end else if (!enable) begin
        state          <= IDLE;
        busy           <= 1'b0;
        counter        <= '0;
        divided_clk    <= 1'b0;
        filter_reset_n <= 1'b0;
        sample_valid   <= 1'b0;
      end else if (state == FLUSH) begin
        if (flush_cnt) begin
          state          <= SETTLE;
          counter        <= '0;
          filter_reset_n <= 1'b1;
          discard_cnt    <= '0;
        end else begin
          flush_cnt <= 1'b1;
        end
      end else begin
        counter     <= (cnt_ext == d_last) ? '0 : counter + 1'b1;
        divided_clk <= (cnt_ext >= half);
        if (at_cap && state == SETTLE) begin
          discard_cnt <= discard_cnt + 1'b1;
          if (discard_cnt == DW'(SETTLE_SAMPLES - 1))
            state <= RUN;
          if (sample_valid && sample_ready)
            sample_valid <= 1'b0;
        end else if (at_cap) begin
          if (!sample_valid || sample_ready) begin
            sample_data  <= cic_out;
            sample_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else if (sample_valid && sample_ready) begin
          sample_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cic3_decim_ctrl.sv
// Testbench for cic3_decim_ctrl: randomized stimulus checked against a
// timeline model (cycles since enable, capture index by arithmetic).
module tb_cic3_decim_ctrl;

  localparam int NB = 25;
  localparam int SS = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [3:0]    dec_log2 = 4'd3;
  logic [NB-1:0] cic_out = '0;
  logic          sample_ready = 1'b0;
  logic          overrun_clr = 1'b0;
  logic          divided_clk;
  logic          filter_reset_n;
  logic [NB-1:0] sample_data;
  logic          sample_valid;
  logic          overrun;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: m_t counts cycles since the enable edge (FLUSH = 1,2).
  bit          m_active = 0;
  int          m_t = 0;
  int          m_D = 8;
  bit          m_valid = 0;
  logic [NB-1:0] m_data = '0;
  bit          m_ovr = 0;

  cic3_decim_ctrl #(.MAX_DEC_LOG2(8), .NUMBITS(NB), .SETTLE_SAMPLES(SS)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .dec_log2(dec_log2),
    .cic_out(cic_out), .divided_clk(divided_clk), .filter_reset_n(filter_reset_n),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .overrun(overrun), .overrun_clr(overrun_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int eff_of(input int d);
    if (d < 3) return 3;
    if (d > 8) return 8;
    return d;
  endfunction

  // True when the coming edge is a RUN capture point.
  function automatic bit cap_now();
    int n;
    n = m_t - 3;
    return m_active && enable && reset_n && n >= 0 &&
           (n % m_D) == (m_D / 2 + 2) && (n / m_D) >= SS;
  endfunction

  function automatic bit exp_dclk();
    return m_active && m_t >= 4 && ((m_t - 4) % m_D) >= m_D / 2;
  endfunction

  function automatic bit exp_frn();
    return m_active && m_t >= 3;
  endfunction

  task automatic tick();
    bit ovr_set;
    ovr_set = 0;
    if (!reset_n) begin
      m_active = 0; m_t = 0; m_valid = 0; m_data = '0; m_ovr = 0;
    end else begin
      if (!m_active) begin
        if (enable) begin
          m_active = 1; m_t = 1; m_D = 1 << eff_of(int'(dec_log2));
        end
      end else if (!enable) begin
        m_active = 0; m_valid = 0;
      end else begin
        if (cap_now()) begin
          if (!m_valid || sample_ready) begin
            m_data = cic_out; m_valid = 1;
          end else begin
            ovr_set = 1;
          end
        end else if (m_valid && sample_ready) begin
          m_valid = 0;
        end
        m_t++;
      end
      if (ovr_set) m_ovr = 1;
      else if (overrun_clr) m_ovr = 0;
    end
    @(posedge clk);
    #1;
    cic_out = NB'($urandom);
  endtask

  task automatic do_reset();
    reset_n = 0; enable = 0; sample_ready = 0; overrun_clr = 0;
    tick(); tick();
    reset_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (divided_clk !== 1'b0) begin n_errors++; $display("FAIL reset_dclk got %b want 0", divided_clk); end
    n_checks++; if (filter_reset_n !== 1'b0) begin n_errors++; $display("FAIL reset_frn got %b want 0", filter_reset_n); end
    n_checks++; if (sample_data !== '0) begin n_errors++; $display("FAIL reset_data got %0h want 0", sample_data); end
    n_checks++; if (sample_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", sample_valid); end
    n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_start_timing();
    do_reset();
    dec_log2 = 4'd3; enable = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_checks++; if (busy !== m_active) begin n_errors++; $display("FAIL start_busy t=%0d got %b want %b", m_t, busy, m_active); end
      n_checks++; if (filter_reset_n !== exp_frn()) begin n_errors++; $display("FAIL start_frn t=%0d got %b want %b", m_t, filter_reset_n, exp_frn()); end
      n_checks++; if (divided_clk !== exp_dclk()) begin n_errors++; $display("FAIL start_dclk t=%0d got %b want %b", m_t, divided_clk, exp_dclk()); end
    end
  endtask

  task automatic test_settle_discard();
    int first_t;
    first_t = -1;
    do_reset();
    dec_log2 = 4'd3; sample_ready = 0; enable = 1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (sample_valid === 1'b1 && first_t < 0) first_t = m_t;
      n_checks++; if (sample_valid !== m_valid) begin n_errors++; $display("FAIL settle_valid t=%0d got %b want %b", m_t, sample_valid, m_valid); end
      n_checks++; if (sample_data !== m_data) begin n_errors++; $display("FAIL settle_data t=%0d got %0h want %0h", m_t, sample_data, m_data); end
    end
    // 4th capture at counter 6 of the 4th period: n=30, t=33, valid seen at t=34.
    n_checks++; if (first_t != 34) begin n_errors++; $display("FAIL settle_first_valid got t=%0d want t=34", first_t); end
  endtask

  task automatic test_backpressure();
    logic [NB-1:0] first;
    do_reset();
    dec_log2 = 4'd3; sample_ready = 0; enable = 1;
    for (int i = 0; i < 200 && !m_valid; i++) tick();
    first = m_data;
    n_checks++; if (sample_valid !== 1'b1) begin n_errors++; $display("FAIL bp_first_valid got %b want 1", sample_valid); end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 40 && !cap_now(); i++) tick();
      tick();
    end
    n_checks++; if (sample_data !== first) begin n_errors++; $display("FAIL bp_data_kept got %0h want %0h", sample_data, first); end
    n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL bp_overrun got %b want 1", overrun); end
    overrun_clr = 1; tick(); overrun_clr = 0;
    n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL bp_clear got %b want 0", overrun); end
    for (int i = 0; i < 40 && !cap_now(); i++) tick();
    overrun_clr = 1; tick(); overrun_clr = 0;
    n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL bp_set_wins got %b want 1", overrun); end
    n_checks++; if (sample_data !== first) begin n_errors++; $display("FAIL bp_data_kept2 got %0h want %0h", sample_data, first); end
  endtask

  task automatic test_accept_load();
    logic [NB-1:0] saved;
    do_reset();
    dec_log2 = 4'd3; sample_ready = 1; enable = 1;
    for (int i = 0; i < 200 && !m_valid; i++) tick();
    sample_ready = 0;
    tick();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 40 && !cap_now(); i++) begin
        tick();
        n_checks++; if (sample_valid !== 1'b1) begin n_errors++; $display("FAIL acc_hold_valid got %b want 1", sample_valid); end
      end
      sample_ready = 1; saved = cic_out;
      tick();
      sample_ready = 0;
      n_checks++; if (sample_valid !== 1'b1) begin n_errors++; $display("FAIL acc_valid got %b want 1", sample_valid); end
      n_checks++; if (sample_data !== saved) begin n_errors++; $display("FAIL acc_data got %0h want %0h", sample_data, saved); end
      n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL acc_overrun got %b want 0", overrun); end
    end
  endtask

  task automatic test_clamp();
    int last_rise, period, cnt;
    bit prev;
    int ratios[2];
    int wants[2];
    ratios[0] = 1; wants[0] = 8;
    ratios[1] = 12; wants[1] = 256;
    for (int r = 0; r < 2; r++) begin
      do_reset();
      dec_log2 = 4'(ratios[r]); sample_ready = 1; enable = 1;
      last_rise = -1; period = -1; cnt = 0; prev = 0;
      for (int i = 0; i < 700 && period < 0; i++) begin
        tick(); cnt++;
        if (divided_clk === 1'b1 && !prev) begin
          if (last_rise >= 0) period = cnt - last_rise;
          last_rise = cnt;
        end
        prev = divided_clk;
      end
      n_checks++; if (period != wants[r]) begin n_errors++; $display("FAIL clamp_period dec_log2=%0d got %0d want %0d", ratios[r], period, wants[r]); end
    end
    // D=256: 4th capture at n=130+768=898, t=901, so valid first seen at t=902.
    for (int i = 0; i < 1200 && sample_valid !== 1'b1; i++) tick();
    n_checks++; if (m_t != 902) begin n_errors++; $display("FAIL clamp_first_capture got t=%0d want t=902", m_t); end
    n_checks++; if (sample_data !== m_data) begin n_errors++; $display("FAIL clamp_data got %0h want %0h", sample_data, m_data); end
    dec_log2 = 4'd3;
    last_rise = -1; period = -1; cnt = 0; prev = divided_clk;
    for (int i = 0; i < 700 && period < 0; i++) begin
      tick(); cnt++;
      if (divided_clk === 1'b1 && !prev) begin
        if (last_rise >= 0) period = cnt - last_rise;
        last_rise = cnt;
      end
      prev = divided_clk;
    end
    n_checks++; if (period != 256) begin n_errors++; $display("FAIL latch_period got %0d want 256", period); end
  endtask

  task automatic test_stop_and_reset();
    logic [NB-1:0] held;
    do_reset();
    dec_log2 = 4'd4; sample_ready = 0; enable = 1;
    for (int i = 0; i < 400 && !m_ovr; i++) tick();
    for (int i = 0; i < 5; i++) tick();
    held = m_data;
    enable = 0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL stop_busy got %b want 0", busy); end
    n_checks++; if (divided_clk !== 1'b0) begin n_errors++; $display("FAIL stop_dclk got %b want 0", divided_clk); end
    n_checks++; if (filter_reset_n !== 1'b0) begin n_errors++; $display("FAIL stop_frn got %b want 0", filter_reset_n); end
    n_checks++; if (sample_valid !== 1'b0) begin n_errors++; $display("FAIL stop_valid got %b want 0", sample_valid); end
    n_checks++; if (sample_data !== held) begin n_errors++; $display("FAIL stop_data got %0h want %0h", sample_data, held); end
    n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL stop_overrun got %b want 1", overrun); end
    tick();
    enable = 1; sample_ready = 1;
    for (int i = 0; i < 120; i++) begin
      tick();
      n_checks++; if (filter_reset_n !== exp_frn() || divided_clk !== exp_dclk() || sample_valid !== m_valid) begin
        n_errors++; $display("FAIL restart t=%0d got frn=%b dclk=%b valid=%b want %b %b %b",
                             m_t, filter_reset_n, divided_clk, sample_valid, exp_frn(), exp_dclk(), m_valid);
      end
    end
    reset_n = 0;
    tick();
    n_checks++; if ({divided_clk, filter_reset_n, sample_valid, overrun, busy} !== 5'b0 || sample_data !== '0) begin
      n_errors++; $display("FAIL midrun_reset got dclk=%b frn=%b valid=%b ovr=%b busy=%b data=%0h want all 0",
                           divided_clk, filter_reset_n, sample_valid, overrun, busy, sample_data);
    end
    reset_n = 1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      sample_ready = ($urandom_range(9) < 6);
      overrun_clr  = ($urandom_range(19) == 0);
      dec_log2     = 4'($urandom_range(6));
      if (!enable) enable = ($urandom_range(9) == 0);
      else if ($urandom_range(499) == 0) enable = 0;
      tick();
      n_checks++; if (divided_clk !== exp_dclk()) begin n_errors++; $display("FAIL rnd_dclk i=%0d got %b want %b", i, divided_clk, exp_dclk()); end
      n_checks++; if (filter_reset_n !== exp_frn()) begin n_errors++; $display("FAIL rnd_frn i=%0d got %b want %b", i, filter_reset_n, exp_frn()); end
      n_checks++; if (busy !== m_active) begin n_errors++; $display("FAIL rnd_busy i=%0d got %b want %b", i, busy, m_active); end
      n_checks++; if (sample_valid !== m_valid) begin n_errors++; $display("FAIL rnd_valid i=%0d got %b want %b", i, sample_valid, m_valid); end
      n_checks++; if (sample_data !== m_data) begin n_errors++; $display("FAIL rnd_data i=%0d got %0h want %0h", i, sample_data, m_data); end
      n_checks++; if (overrun !== m_ovr) begin n_errors++; $display("FAIL rnd_overrun i=%0d got %b want %b", i, overrun, m_ovr); end
    end
    overrun_clr = 0;
  endtask

  initial begin
    #2;
    test_reset();
    test_start_timing();
    test_settle_discard();
    test_backpressure();
    test_accept_load();
    test_clamp();
    test_stop_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
